// File: rtl/smart_cargo_pkg.sv
// Shared types for the smart_cargo_n cargo lift controller:
// FSM encoding, queue-entry record and sensor helpers.
package smart_cargo_pkg;

  localparam int MAX_FLOOR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECIDE   = 3'd1,
    ST_SUBINDO  = 3'd2,
    ST_DESCENDO = 3'd3,
    ST_DWELL    = 3'd4,
    ST_EMERG    = 3'd5
  } state_t;

  typedef struct packed {
    logic [MAX_FLOOR_W-1:0] floor;
    logic                   eh_origem;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [MAX_FLOOR_W-1:0] onehot_idx(
    input logic [15:0] v
  );
    logic [MAX_FLOOR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = i[MAX_FLOOR_W-1:0];
    return idx;
  endfunction

endpackage

// File: rtl/smart_cargo_fila.sv
// Stop queue: circular buffer with two ordered write ports
// (wr0 lands before wr1) and one read port at the head.
module smart_cargo_fila
  import smart_cargo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr0_en,
  input  logic [W-1:0] wr0_data,
  input  logic         wr1_en,
  input  logic [W-1:0] wr1_data,
  input  logic         rd_en,
  output logic [W-1:0] head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr1_addr;
  logic [1:0]    n_wr;
  logic          pop;

  assign pop      = rd_en && !empty;
  assign n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign wr1_addr = wr0_en ? wr_ptr + 1'b1 : wr_ptr;

  always_ff @(posedge clock) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_en) mem[wr1_addr] <= wr1_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_wr);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(n_wr) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/smart_cargo_n.sv
// Cargo lift controller: request intake, stop queue, travel/dwell FSM.
// Optional ride-sharing of the tail stop: define SMART_CARGO_CARONA_EN.
module smart_cargo_n
  import smart_cargo_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int QUEUE_DEPTH  = 8,
  parameter int DWELL_CYCLES = 100000000,
  localparam int FLOOR_W =
    ($clog2(NUM_FLOORS) > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] sensores,
  input  logic                  emergencia,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_origem,
  input  logic [FLOOR_W-1:0]    req_destino,
  output logic                  req_ready,
  output logic                  req_erro,
  output logic                  motor_subindo,
  output logic                  motor_descendo,
  output logic                  coloca_objetos,
  output logic                  tira_objetos,
  output logic [FLOOR_W-1:0]    andar_atual,
  output logic [FLOOR_W-1:0]    prox_parada,
  output logic                  fila_vazia,
  output logic                  fila_cheia,
  output logic [2:0]            db_estado
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int DW = $clog2(DWELL_CYCLES);

  state_t state;
  state_t state_n;

  logic [MAX_FLOOR_W-1:0] andar_q;
  logic [NUM_FLOORS-1:0]  sens_q;
  logic [15:0]            sens_x;
  logic                   sens_hit;

  entry_t          head;
  logic [CW-1:0]   count;
  logic            pop;

  logic            pend_valid;
  entry_t          pend_wr0;
  logic            pend_wr1_en;
  entry_t          pend_wr1;

  logic [MAX_FLOOR_W-1:0] orig_f;
  logic [MAX_FLOOR_W-1:0] dest_f;
  logic            hs;
  logic            bad;
  logic            carona;
  logic            dup;
  logic [1:0]      need;
  logic [CW-1:0]   free;

  logic [DW-1:0]   dwell_cnt;
  logic            dwell_last;
  logic            rel_q;

  // Sensors: accept only a clean one-hot pattern with a fresh rising bit.
  assign sens_x   = 16'(sensores);
  assign sens_hit = is_onehot(sens_x) &&
                    ((sensores & ~sens_q) != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sens_q  <= '0;
      andar_q <= '0;
    end else begin
      sens_q <= sensores;
      if (sens_hit) andar_q <= onehot_idx(sens_x);
    end
  end

  assign orig_f = MAX_FLOOR_W'(req_origem);
  assign dest_f = MAX_FLOOR_W'(req_destino);
  assign bad    = (req_origem == req_destino) ||
                  (32'(req_origem) >= NUM_FLOORS) ||
                  (32'(req_destino) >= NUM_FLOORS);

`ifdef SMART_CARGO_CARONA_EN
  logic [MAX_FLOOR_W-1:0] ult_floor;

  // A tail stop about to be popped no longer counts as a shared pickup.
  assign carona = !fila_vazia && !(pop && count == CW'(1)) &&
                  (ult_floor == orig_f);
  assign dup    = carona && (dest_f == ult_floor);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ult_floor <= '0;
    else if (pend_valid)
      ult_floor <= pend_wr1_en ? pend_wr1.floor : pend_wr0.floor;
  end
`else
  assign carona = 1'b0;
  assign dup    = 1'b0;
`endif

  assign need      = carona ? 2'd1 : 2'd2;
  assign free      = CW'(QUEUE_DEPTH) - count;
  assign req_ready = (state != ST_EMERG) && !pend_valid &&
                     (free >= CW'(need));
  assign hs        = req_valid && req_ready;

  // Accepted requests land in the queue one cycle after the handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_erro    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_wr0    <= '0;
      pend_wr1_en <= 1'b0;
      pend_wr1    <= '0;
    end else begin
      req_erro   <= hs && bad;
      pend_valid <= hs && !bad && !dup;
      if (hs) begin
        pend_wr0    <= carona ? '{floor: dest_f, eh_origem: 1'b0}
                              : '{floor: orig_f, eh_origem: 1'b1};
        pend_wr1_en <= !carona;
        pend_wr1    <= '{floor: dest_f, eh_origem: 1'b0};
      end
    end
  end

  smart_cargo_fila #(
    .DEPTH (QUEUE_DEPTH),
    .W     (ENTRY_W)
  ) u_fila (
    .clock    (clock),
    .reset    (reset),
    .wr0_en   (pend_valid),
    .wr0_data (pend_wr0),
    .wr1_en   (pend_valid && pend_wr1_en),
    .wr1_data (pend_wr1),
    .rd_en    (pop),
    .head     (head),
    .count    (count),
    .empty    (fila_vazia),
    .full     (fila_cheia)
  );

  assign dwell_last = (dwell_cnt == DW'(DWELL_CYCLES - 1));

  always_comb begin
    state_n        = state;
    pop            = 1'b0;
    motor_subindo  = 1'b0;
    motor_descendo = 1'b0;
    coloca_objetos = 1'b0;
    tira_objetos   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fila_vazia) state_n = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (fila_vazia)            state_n = ST_IDLE;
        else if (head.floor > andar_q) state_n = ST_SUBINDO;
        else if (head.floor < andar_q) state_n = ST_DESCENDO;
        else                       state_n = ST_DWELL;
      end
      ST_SUBINDO: begin
        if (andar_q == head.floor) state_n = ST_DWELL;
        else                       motor_subindo = 1'b1;
      end
      ST_DESCENDO: begin
        if (andar_q == head.floor) state_n = ST_DWELL;
        else                       motor_descendo = 1'b1;
      end
      ST_DWELL: begin
        coloca_objetos = head.eh_origem;
        tira_objetos   = !head.eh_origem;
        if (dwell_last) begin
          pop     = 1'b1;
          state_n = (count > CW'(1) || pend_valid) ? ST_DECIDE : ST_IDLE;
        end
      end
      ST_EMERG: begin
        motor_subindo  = 1'b1;
        motor_descendo = 1'b1;
        if (!emergencia && rel_q)
          state_n = (!fila_vazia || pend_valid) ? ST_DECIDE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (emergencia) begin
      state_n = ST_EMERG;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      rel_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_DWELL && state_n == ST_DWELL)
        dwell_cnt <= dwell_cnt + 1'b1;
      else
        dwell_cnt <= '0;
      rel_q <= (state == ST_EMERG) && !emergencia;
    end
  end

  assign andar_atual = andar_q[FLOOR_W-1:0];
  assign prox_parada = fila_vazia ? '0 : head.floor[FLOOR_W-1:0];
  assign db_estado   = state;

endmodule

// File: tb/tb_smart_cargo_n.sv
// Directed bench for smart_cargo_n: 4 floors, depth 4, dwell 4.
// Ride-sharing scenario runs only when SMART_CARGO_CARONA_EN is set.
module tb_smart_cargo_n;

  localparam int NF = 4;
  localparam int QD = 4;
  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sensores = '0;
  logic       emergencia = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_origem = '0;
  logic [1:0] req_destino = '0;
  logic       req_ready;
  logic       req_erro;
  logic       motor_subindo;
  logic       motor_descendo;
  logic       coloca_objetos;
  logic       tira_objetos;
  logic [1:0] andar_atual;
  logic [1:0] prox_parada;
  logic       fila_vazia;
  logic       fila_cheia;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  smart_cargo_n #(
    .NUM_FLOORS   (NF),
    .QUEUE_DEPTH  (QD),
    .DWELL_CYCLES (DC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sensores       (sensores),
    .emergencia     (emergencia),
    .req_valid      (req_valid),
    .req_origem     (req_origem),
    .req_destino    (req_destino),
    .req_ready      (req_ready),
    .req_erro       (req_erro),
    .motor_subindo  (motor_subindo),
    .motor_descendo (motor_descendo),
    .coloca_objetos (coloca_objetos),
    .tira_objetos   (tira_objetos),
    .andar_atual    (andar_atual),
    .prox_parada    (prox_parada),
    .fila_vazia     (fila_vazia),
    .fila_cheia     (fila_cheia),
    .db_estado      (db_estado)
  );

  task automatic send(input logic [1:0] o, input logic [1:0] d);
    req_valid   = 1'b1;
    req_origem  = o;
    req_destino = d;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado !== 3'd0) begin
      errors++; $display("FAIL rst_state got %0d want 0", db_estado);
    end
    checks++;
    if (fila_vazia !== 1'b1 || fila_cheia !== 1'b0) begin
      errors++;
      $display("FAIL rst_fila got %b%b want 10", fila_vazia, fila_cheia);
    end
    checks++;
    if (prox_parada !== 2'd0 || andar_atual !== 2'd0) begin
      errors++;
      $display("FAIL rst_floor got %0d/%0d want 0/0",
               prox_parada, andar_atual);
    end
    checks++;
    if ({motor_subindo, motor_descendo, coloca_objetos, tira_objetos,
         req_erro} !== 5'b0) begin
      errors++; $display("FAIL rst_outs got nonzero want 0");
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_erro;
    send(2'd2, 2'd2);
    checks++;
    if (req_erro !== 1'b1) begin
      errors++; $display("FAIL erro_pulse got %b want 1", req_erro);
    end
    checks++;
    if (fila_vazia !== 1'b1) begin
      errors++; $display("FAIL erro_vazia got %b want 1", fila_vazia);
    end
    @(negedge clock);
    checks++;
    if (req_erro !== 1'b0 || fila_vazia !== 1'b1) begin
      errors++;
      $display("FAIL erro_once got %b/%b want 0/1", req_erro, fila_vazia);
    end
  endtask

  task automatic test_travel;
    send(2'd0, 2'd3);
    for (int i = 0; i < 20 && !coloca_objetos; i++) @(negedge clock);
    checks++;
    if (coloca_objetos !== 1'b1 || andar_atual !== 2'd0) begin
      errors++;
      $display("FAIL trv_load got %b@%0d want 1@0",
               coloca_objetos, andar_atual);
    end
    n = 0;
    while (coloca_objetos && n < 20) begin n++; @(negedge clock); end
    checks++;
    if (n != DC) begin
      errors++; $display("FAIL trv_load_len got %0d want %0d", n, DC);
    end
    for (int i = 0; i < 10 && !motor_subindo; i++) @(negedge clock);
    checks++;
    if (motor_subindo !== 1'b1 || motor_descendo !== 1'b0 ||
        prox_parada !== 2'd3) begin
      errors++;
      $display("FAIL trv_up got %b%b p%0d want 10 p3",
               motor_subindo, motor_descendo, prox_parada);
    end
    sensores = 4'b0010;
    @(negedge clock);
    checks++;
    if (andar_atual !== 2'd1 || motor_subindo !== 1'b1) begin
      errors++;
      $display("FAIL trv_f1 got %0d/%b want 1/1", andar_atual, motor_subindo);
    end
    emergencia = 1'b1;
    @(negedge clock);
    checks++;
    if ({motor_subindo, motor_descendo} !== 2'b11 || db_estado !== 3'd5) begin
      errors++;
      $display("FAIL emg_brake got %b%b s%0d want 11 s5",
               motor_subindo, motor_descendo, db_estado);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL emg_ready got %b want 0", req_ready);
    end
    emergencia = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 3'd5) begin
      errors++; $display("FAIL emg_hold got %0d want 5", db_estado);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 3'd1 || prox_parada !== 2'd3) begin
      errors++;
      $display("FAIL emg_resume got s%0d p%0d want s1 p3",
               db_estado, prox_parada);
    end
    @(negedge clock);
    checks++;
    if (motor_subindo !== 1'b1 || motor_descendo !== 1'b0) begin
      errors++;
      $display("FAIL emg_up got %b%b want 10", motor_subindo, motor_descendo);
    end
    sensores = 4'b0110;
    @(negedge clock);
    checks++;
    if (andar_atual !== 2'd1) begin
      errors++; $display("FAIL sens_multi got %0d want 1", andar_atual);
    end
    sensores = 4'b0000;
    @(negedge clock);
    sensores = 4'b1000;
    @(negedge clock);
    checks++;
    if (andar_atual !== 2'd3 || motor_subindo !== 1'b0 ||
        db_estado !== 3'd2) begin
      errors++;
      $display("FAIL trv_arrive got %0d/%b s%0d want 3/0 s2",
               andar_atual, motor_subindo, db_estado);
    end
    for (int i = 0; i < 5 && !tira_objetos; i++) @(negedge clock);
    n = 0;
    while (tira_objetos && n < 20) begin n++; @(negedge clock); end
    checks++;
    if (n != DC) begin
      errors++; $display("FAIL trv_unload_len got %0d want %0d", n, DC);
    end
    checks++;
    if (db_estado !== 3'd0 || fila_vazia !== 1'b1) begin
      errors++;
      $display("FAIL trv_idle got s%0d v%b want s0 v1",
               db_estado, fila_vazia);
    end
  endtask

  task automatic test_full;
    send(2'd1, 2'd2);
    for (int i = 0; i < 5 && !req_ready; i++) @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready2 got %b want 1", req_ready);
    end
    send(2'd0, 2'd2);
    @(negedge clock);
    checks++;
    if (fila_cheia !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_set got %b/%b want 1/0", fila_cheia, req_ready);
    end
    for (int i = 0; i < 5 && !motor_descendo; i++) @(negedge clock);
    checks++;
    if (motor_descendo !== 1'b1 || motor_subindo !== 1'b0) begin
      errors++;
      $display("FAIL full_down got %b%b want 01", motor_subindo, motor_descendo);
    end
    sensores = 4'b0010;
    for (int i = 0; i < 5 && !coloca_objetos; i++) @(negedge clock);
    for (int i = 0; i < 20 && coloca_objetos; i++) @(negedge clock);
    checks++;
    if (fila_cheia !== 1'b0 || req_ready !== 1'b0 || prox_parada !== 2'd2) begin
      errors++;
      $display("FAIL full_pop1 got %b/%b p%0d want 0/0 p2",
               fila_cheia, req_ready, prox_parada);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0 || motor_subindo !== 1'b1) begin
      errors++;
      $display("FAIL full_hold got %b/%b want 0/1", req_ready, motor_subindo);
    end
    sensores = 4'b0100;
    for (int i = 0; i < 5 && !tira_objetos; i++) @(negedge clock);
    for (int i = 0; i < 20 && tira_objetos; i++) @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || prox_parada !== 2'd0) begin
      errors++;
      $display("FAIL full_pop2 got %b p%0d want 1 p0", req_ready, prox_parada);
    end
    @(negedge clock);
    checks++;
    if (motor_descendo !== 1'b1) begin
      errors++; $display("FAIL full_down2 got %b want 1", motor_descendo);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (motor_descendo !== 1'b0 || db_estado !== 3'd0 ||
        fila_vazia !== 1'b1 || andar_atual !== 2'd0) begin
      errors++;
      $display("FAIL rst_motion got d%b s%0d v%b a%0d want d0 s0 v1 a0",
               motor_descendo, db_estado, fila_vazia, andar_atual);
    end
    sensores = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

`ifdef SMART_CARGO_CARONA_EN
  task automatic test_carona;
    send(2'd1, 2'd2);
    for (int i = 0; i < 5 && !req_ready; i++) @(negedge clock);
    send(2'd2, 2'd3);
    @(negedge clock);
    checks++;
    if (fila_cheia !== 1'b0 || prox_parada !== 2'd1) begin
      errors++;
      $display("FAIL car_three got %b p%0d want 0 p1",
               fila_cheia, prox_parada);
    end
    sensores = 4'b0010;
    for (int i = 0; i < 10 && !coloca_objetos; i++) @(negedge clock);
    for (int i = 0; i < 20 && coloca_objetos; i++) @(negedge clock);
    checks++;
    if (prox_parada !== 2'd2) begin
      errors++; $display("FAIL car_stop2 got %0d want 2", prox_parada);
    end
    sensores = 4'b0100;
    for (int i = 0; i < 10 && !tira_objetos; i++) @(negedge clock);
    for (int i = 0; i < 20 && tira_objetos; i++) @(negedge clock);
    checks++;
    if (prox_parada !== 2'd3 || fila_vazia !== 1'b0) begin
      errors++;
      $display("FAIL car_stop3 got p%0d v%b want p3 v0",
               prox_parada, fila_vazia);
    end
    sensores = 4'b1000;
    for (int i = 0; i < 10 && !tira_objetos; i++) @(negedge clock);
    for (int i = 0; i < 20 && tira_objetos; i++) @(negedge clock);
    checks++;
    if (fila_vazia !== 1'b1) begin
      errors++; $display("FAIL car_done got %b want 1", fila_vazia);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_erro();
    test_travel();
    test_full();
`ifdef SMART_CARGO_CARONA_EN
    test_carona();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
